// File: rtl/feature_tx_pkg.sv
// Shared types and constants for the feature TX drain path.
package feature_tx_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 13;
  localparam logic [DATA_W/8-1:0] KEEP_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_LATCH,
    ST_STREAM,
    ST_FLUSH
  } tx_state_e;

endpackage

// File: rtl/tx_out_queue.sv
// Small first-word-fall-through queue carrying stream data plus a tlast sideband.
module tx_out_queue #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned PW     = $clog2(DEPTH)
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head,
  output logic              head_last
);

  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  assign {head_last, head} = mem[rd_ptr];

endmodule

// File: rtl/tx_buffer_reader.sv
// Drains a snapshotted number of words from the TX FIFO into one AXI4-Stream frame,
// buffering read returns in a small queue so tready backpressure never drops a word.
module tx_buffer_reader #(
  parameter int unsigned DATA_W  = feature_tx_pkg::DATA_W,
  parameter int unsigned CNT_W   = feature_tx_pkg::CNT_W,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                read_start,
  input  logic [CNT_W-1:0]    buffer_data_count,
  output logic                buffer_rd_en,
  input  logic [DATA_W-1:0]   buffer_rd_data,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  import feature_tx_pkg::*;

  localparam int unsigned QC_W  = $clog2(Q_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(Q_DEPTH + RD_LAT + 2);

  tx_state_e         state;
  logic [CNT_W-1:0]  words_left;
  logic [CNT_W-1:0]  words_to_send;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occ;
  logic [QC_W-1:0]   q_count;
  logic [DATA_W-1:0] q_head;
  logic              q_head_last;
  logic              push;
  logic              pop;
  logic              flush_done;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(pipe_vld[i]);
  end

  // Reads in flight reserve queue slots so a stalled sink can never overflow the queue.
  assign occ           = OCC_W'(q_count) + inflight;
  assign m_axis_tvalid = (q_count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign push          = pipe_vld[RD_LAT-1];
  assign buffer_rd_en  = (state == ST_STREAM) && (words_left != '0) &&
                         (occ < OCC_W'(Q_DEPTH) + OCC_W'(pop));

  assign m_axis_tdata  = m_axis_tvalid ? q_head : '0;
  assign m_axis_tlast  = m_axis_tvalid && q_head_last;
  assign m_axis_tkeep  = {(DATA_W/8){m_axis_tvalid}};

  assign flush_done = (inflight == '0) &&
                      ((q_count == '0) || ((q_count == QC_W'(1)) && pop)) &&
                      ((words_to_send == '0) || ((words_to_send == CNT_W'(1)) && pop));

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= buffer_rd_en;
      pipe_last[0] <= buffer_rd_en && (words_left == CNT_W'(1));
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      read_start    <= 1'b0;
      words_left    <= '0;
      words_to_send <= '0;
    end else begin
      read_start <= 1'b0;
      done       <= 1'b0;
      if (buffer_rd_en) words_left <= words_left - CNT_W'(1);
      if (pop && (words_to_send != '0)) words_to_send <= words_to_send - CNT_W'(1);
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SNAP;
            read_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_SNAP: state <= ST_LATCH;
        ST_LATCH: begin
          words_left    <= buffer_data_count;
          words_to_send <= buffer_data_count;
          if (buffer_data_count == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (buffer_rd_en && (words_left == CNT_W'(1))) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tx_out_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (Q_DEPTH)
  ) u_out_queue (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .push      (push),
    .push_data (buffer_rd_data),
    .push_last (pipe_last[RD_LAT-1]),
    .pop       (pop),
    .count     (q_count),
    .head      (q_head),
    .head_last (q_head_last)
  );

endmodule

// File: tb/tb_tx_buffer_reader.sv
// Directed bench for tx_buffer_reader with a behavioural FIFO (registered dout, 1-cycle latency).
module tb_tx_buffer_reader;
  import feature_tx_pkg::*;

  localparam int Q_DEPTH = 4;

  logic                sclk = 1'b0;
  logic                s_rst_n = 1'b0;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic                read_start;
  logic [CNT_W-1:0]    buffer_data_count = '0;
  logic                buffer_rd_en;
  logic [DATA_W-1:0]   buffer_rd_data;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b0;
  logic                m_axis_tlast;

  always #5 sclk = ~sclk;

  tx_buffer_reader #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .RD_LAT  (1),
    .Q_DEPTH (Q_DEPTH)
  ) dut (
    .sclk              (sclk),
    .s_rst_n           (s_rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .read_start        (read_start),
    .buffer_data_count (buffer_data_count),
    .buffer_rd_en      (buffer_rd_en),
    .buffer_rd_data    (buffer_rd_data),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast)
  );

  // FIFO model: word idx of a frame is {seed, idx}; reads past the snapshot count are underflows.
  logic [31:0] seed = '0;
  int          rd_idx;
  int          underflow = 0;

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_idx         <= 0;
      buffer_rd_data <= '0;
    end else if (read_start) begin
      rd_idx <= 0;
    end else if (buffer_rd_en) begin
      if (rd_idx >= int'(buffer_data_count)) underflow <= underflow + 1;
      buffer_rd_data <= {seed, 32'(rd_idx)};
      rd_idx         <= rd_idx + 1;
    end
  end

  int checks = 0;
  int passed = 0;

  int cyc, cur_cnt, mode, stall_lo, stall_hi;
  int rs_seen, rd_seen, beats, last_seen, done_seen;
  int first_rs, first_rd, first_tv, done_cyc;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 0);
    chk({tag, "_tdata"},  m_axis_tdata, 0);
    chk({tag, "_tkeep"},  64'(m_axis_tkeep), 0);
    chk({tag, "_tlast"},  64'(m_axis_tlast), 0);
    chk({tag, "_busy"},   64'(busy), 0);
    chk({tag, "_done"},   64'(done), 0);
    chk({tag, "_rstart"}, 64'(read_start), 0);
    chk({tag, "_rd_en"},  64'(buffer_rd_en), 0);
  endtask

  // One clock: drive inputs on the falling edge, then sample what the next rising edge will see.
  task automatic cycle(input logic st);
    @(negedge sclk);
    start = st;
    case (mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = !(cyc >= stall_lo && cyc <= stall_hi);
    endcase
    #1;
    if (prev_stall && m_axis_tvalid) chk("hold_tdata", m_axis_tdata, prev_data);
    chk("outstanding", 64'((rd_seen - beats) <= Q_DEPTH), 1);
    if (read_start) begin
      rs_seen++;
      if (first_rs < 0) first_rs = cyc;
      chk("busy_at_snap", 64'(busy), 1);
    end
    if (buffer_rd_en) begin
      rd_seen++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      chk("beat_data", m_axis_tdata, {seed, 32'(beats)});
      chk("beat_last", 64'(m_axis_tlast), 64'(beats == cur_cnt - 1));
      chk("beat_keep", 64'(m_axis_tkeep), 64'(KEEP_ALL));
      if (m_axis_tlast) last_seen++;
      beats++;
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
      chk("busy_at_done", 64'(busy), 0);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    cyc++;
  endtask

  task automatic run_frame(input string tag, input int cnt, input int md, input int repulse_at,
                           input int abort_after, input int exp_done, input int budget);
    int u0;
    mode = md; cur_cnt = cnt; buffer_data_count = CNT_W'(cnt); seed = $urandom;
    cyc = 0; rs_seen = 0; rd_seen = 0; beats = 0; last_seen = 0; done_seen = 0;
    first_rs = -1; first_rd = -1; first_tv = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_data = '0; u0 = underflow;
    cycle(1'b1);
    while (cyc < budget) begin
      if (done_seen > 0 && cyc > done_cyc + 6) break;
      cycle((repulse_at > 0) && (cyc == repulse_at || cyc == repulse_at + 3));
      if (abort_after > 0 && beats == abort_after) begin
        s_rst_n = 1'b0;
        #1;
        chk_outputs_zero({tag, "_abort"});
        @(negedge sclk);
        s_rst_n = 1'b1;
        start = 1'b0;
        return;
      end
    end
    if (abort_after > 0) chk({tag, "_abort_reached"}, 64'(beats), 64'(abort_after));
    chk({tag, "_done_cnt"},  64'(done_seen), 1);
    chk({tag, "_rs_cnt"},    64'(rs_seen), 1);
    chk({tag, "_rs_cyc"},    64'(first_rs), 1);
    chk({tag, "_rd_cnt"},    64'(rd_seen), 64'(cnt));
    chk({tag, "_beats"},     64'(beats), 64'(cnt));
    chk({tag, "_lasts"},     64'(last_seen), (cnt > 0) ? 64'd1 : 64'd0);
    chk({tag, "_rd_cyc"},    64'(first_rd), (cnt > 0) ? 64'd3 : 64'(-1));
    chk({tag, "_tv_cyc"},    64'(first_tv), (cnt > 0) ? 64'd5 : 64'(-1));
    chk({tag, "_underflow"}, 64'(underflow - u0), 0);
    if (exp_done >= 0) chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
  endtask

  initial begin
    repeat (3) @(negedge sclk);
    #1;
    chk_outputs_zero("reset");
    @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    // count 4, tready high: beats T+5..T+8, done at T+9
    run_frame("f4", 4, 0, 0, 0, 9, 60);
    // empty snapshot: done at T+3, no reads, no beats
    run_frame("f0", 0, 0, 0, 0, 3, 40);
    // sink stalls for 10 cycles mid-frame
    stall_lo = 8; stall_hi = 17;
    run_frame("stall16", 16, 2, 0, 0, -1, 200);
    // start re-pulsed while busy must not spawn a second frame
    run_frame("repulse", 6, 0, 4, 0, -1, 80);
    // reset after the third beat, then a clean 2-word frame
    run_frame("abort10", 10, 0, 0, 3, -1, 80);
    run_frame("after_abort", 2, 0, 0, 0, 7, 40);
    // maximum count with random backpressure
    run_frame("max8191", 8191, 1, 0, 0, -1, 40000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tx_buffer_reader.md
Name: tx_buffer_reader

Overview:
- Drain side of the feature TX FIFO (`feature_fifo_ip`, 64-bit, 13-bit count, standard-mode read: `dout` valid 1 cycle after `rd_en`).
- On a `start` pulse, it requests a count snapshot through `read_start`, then reads exactly that many words.
- It emits them as one AXI4-Stream frame (`tlast` on the final beat) toward the PS DMA.
- A small internal output queue absorbs `tready` backpressure, so no FIFO word is ever lost or duplicated.

Parameters:
- DATA_W, 64, stream/FIFO word width
- CNT_W, 13, width of FIFO count and frame word counter
- RD_LAT, 1, FIFO read latency in cycles (`rd_en` to valid `dout`)
- Q_DEPTH, 4, output queue entries; must be ≥ RD_LAT+2 for full throughput

Ports:
- sclk, in, 1, clock
- s_rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle frame request from control logic
- busy, out, 1, high from accepted start until done
- done, out, 1, one-cycle pulse when the frame is complete or empty
- read_start, out, 1, one-cycle pulse to FIFO wrapper to snapshot data count
- buffer_data_count, in, CNT_W, snapshotted FIFO count
- buffer_rd_en, out, 1, FIFO read strobe
- buffer_rd_data, in, DATA_W, FIFO read data
- m_axis_tdata, out, DATA_W, stream data
- m_axis_tkeep, out, DATA_W/8, all ones while tvalid, else 0
- m_axis_tvalid, out, 1, stream valid
- m_axis_tready, in, 1, stream ready
- m_axis_tlast, out, 1, final beat of frame

Behaviour:
- Reset: clock `sclk`; reset `s_rst_n` is asynchronous, active-low. All outputs are 0; FSM goes to IDLE; counters, in-flight tracker and queue are cleared.
- FSM IDLE→SNAP→LATCH→STREAM→FLUSH→IDLE.
- IDLE: `start`=1 → SNAP. `start` in any other state is ignored (no queuing).
- SNAP: `read_start`=1 for this cycle only; `busy`=1 from here.
- LATCH: sample `buffer_data_count` into `words_left` and `words_to_send`.
  - If 0: `done` pulses next cycle; return to IDLE; no beats, no `rd_en`.
  - Else go to STREAM.
- STREAM, read issue:
  - `buffer_rd_en`=1 iff `words_left`>0 and (`q_count` + `inflight` − `pop_this_cycle`) < Q_DEPTH.
  - Each issue decrements `words_left` and enters an RD_LAT-deep valid shift pipe.
  - The returning word is pushed into the queue exactly RD_LAT cycles after its `rd_en`.
  - When `words_left` reaches 0 → FLUSH.
- Output:
  - `m_axis_tdata`/`tvalid` come from the queue head and are registered.
  - A pop occurs on `tvalid && tready`.
  - While `tvalid`=1 and `tready`=0, `tdata`/`tlast` are held stable.
  - `tlast`=1 exactly on the beat where `words_to_send` decrements to 0.
- FLUSH: wait until `inflight`=0 and the queue is empty and the last beat has handshaked, then `done`=1 for one cycle, `busy`=0, go to IDLE.
- Throughput and latency:
  - With `tready` held high, beats are back-to-back, 1 per cycle.
  - Start latency: `start` at cycle T → `read_start` T+1, count sampled T+2, first `rd_en` T+3, first `tvalid` T+5 (RD_LAT=1).
- Simultaneous push and pop in one cycle: `q_count` is unchanged; ordering is preserved.
- Count of 2^CNT_W−1 (8191 words) must stream correctly; no counter wrap.
- FIFO underflow is not possible by construction: reads never exceed the snapshot count.
- Reset mid-frame: immediate return to IDLE; queue contents are discarded; `tvalid` drops. The FIFO is reset by the same `s_rst_n`, so no stale data remains.

Decomposition:
- Shared package `feature_tx_pkg`:
  - FSM state enum.
  - DATA_W and CNT_W constants.
  - KEEP_ALL constant.
- One sub-module: `tx_out_queue`, a synchronous FWFT queue (push, pop, `count`, `head`, tlast sideband), Q_DEPTH entries.

Test Plan:
1. Count 4, `tready`=1 → `read_start` at T+1; 4 `rd_en`; beats at T+5..T+8 with data D0..D3 in order; `tlast` only on D3; `done` at T+9.
2. Count 0 → `read_start` pulse; no `rd_en`, no `tvalid`; `done` pulse at T+3; `busy` falls.
3. Count 16, `tready` low for 10 cycles mid-frame → at most Q_DEPTH words outstanding; `rd_en` stalls; `tdata` held stable; all 16 words delivered exactly once, in order.
4. Random `tready` (50%), count 8191 → 8191 beats; scoreboard matches; single `tlast`; no FIFO underflow.
5. `start` re-pulsed while busy → ignored; exactly one frame produced; exactly one `done`.
6. `s_rst_n` asserted after beat 3 of 10 → outputs 0 immediately; then a new `start` with count 2 yields a clean 2-beat frame.
